// File: rtl/chess_pkg.sv
// Shared chess encodings: cell layout, piece codes and straight-line scan directions.
// Used by the board scanners and their steppers.
package chess_pkg;

    localparam int CELL_W    = 4;
    localparam int PIECE_W   = 3;
    localparam int COLOR_BIT = 3;

    typedef enum logic [PIECE_W-1:0] {
        PIECE_EMPTY  = 3'd0,
        PIECE_PAWN   = 3'd1,
        PIECE_KNIGHT = 3'd2,
        PIECE_BISHOP = 3'd3,
        PIECE_ROOK   = 3'd4,
        PIECE_QUEEN  = 3'd5,
        PIECE_KING   = 3'd6
    } piece_e;

    // pos = col*8 + row; UP/DOWN move along the row, LEFT/RIGHT along the column.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    function automatic logic is_straight_slider(input logic [PIECE_W-1:0] piece);
        return (piece == PIECE_ROOK) || (piece == PIECE_QUEEN);
    endfunction

endpackage

// File: rtl/square_stepper.sv
// Combinational one-square step on an 8x8 board; flags steps that would leave the board.
module square_stepper
    import chess_pkg::*;
(
    input  logic [5:0] i_pos,
    input  logic [1:0] i_dir,
    output logic [5:0] o_next_pos,
    output logic       o_off_board
);

    logic [2:0] w_row;
    logic [2:0] w_col;

    assign w_row = i_pos[2:0];
    assign w_col = i_pos[5:3];

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        o_next_pos  = i_pos;
        o_off_board = 1'b0;
        case (i_dir)
            DIR_UP: begin
                o_off_board = (w_row == 3'd0);
                o_next_pos  = {w_col, w_row - 3'd1};
            end
            DIR_LEFT: begin
                o_off_board = (w_col == 3'd0);
                o_next_pos  = {w_col - 3'd1, w_row};
            end
            DIR_RIGHT: begin
                o_off_board = (w_col == 3'd7);
                o_next_pos  = {w_col + 3'd1, w_row};
            end
            DIR_DOWN: begin
                o_off_board = (w_row == 3'd7);
                o_next_pos  = {w_col, w_row + 3'd1};
            end
        endcase
    end

endmodule

// File: rtl/straight_check_ctrl.sv
// Sequential rank/file check detector: walks UP, LEFT, RIGHT, DOWN from the king,
// one square per cycle, counting attacked directions and recording the first attacker.
module straight_check_ctrl
    import chess_pkg::*;
#(
    parameter int CELL_W = chess_pkg::CELL_W,
    parameter int NSQ    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CELL_W*NSQ-1:0] bigBoard,
    input  logic [5:0]            king_pos,
    input  logic                  king_color,
    output logic                  busy,
    output logic                  done,
    output logic                  check,
    output logic [5:0]            attacker_pos,
    output logic [1:0]            attacker_dir,
    output logic [2:0]            attack_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            r_dir;
    logic [5:0]            r_cursor;
    logic                  r_off;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_check;
    logic [5:0]            r_att_pos;
    logic [1:0]            r_att_dir;
    logic [2:0]            r_att_cnt;
    logic [CELL_W*NSQ-1:0] r_board;
    logic [5:0]            r_king_pos;
    logic                  r_king_color;

    logic                  w_accept;
    logic [CELL_W-1:0]     w_cell;
    logic                  w_occupied;
    logic                  w_attack;
    logic                  w_dir_end;
    logic [5:0]            w_a_next;
    logic                  w_a_off;
    logic [5:0]            w_b_pos;
    logic [1:0]            w_b_dir;
    logic [5:0]            w_b_next;
    logic                  w_b_off;

    assign w_accept = (r_state == ST_IDLE) && start;

    // The cursor always points at the square to examine; r_off means the direction
    // has no square at all.  Stepper A looks one square past the cursor so a direction
    // ends on its last on-board square, stepper B pre-computes the next direction's first square.
    square_stepper u_step_cursor (
        .i_pos       (r_cursor),
        .i_dir       (r_dir),
        .o_next_pos  (w_a_next),
        .o_off_board (w_a_off)
    );

    always_comb begin
        w_b_pos = r_king_pos;
        w_b_dir = r_dir + 2'd1;
        if (r_state == ST_IDLE) begin
            w_b_pos = king_pos;
            w_b_dir = DIR_UP;
        end
    end

    square_stepper u_step_dir (
        .i_pos       (w_b_pos),
        .i_dir       (w_b_dir),
        .o_next_pos  (w_b_next),
        .o_off_board (w_b_off)
    );

    assign w_cell     = r_board[int'(r_cursor)*CELL_W +: CELL_W];
    assign w_occupied = (w_cell[PIECE_W-1:0] != PIECE_EMPTY);
    assign w_attack   = (r_state == ST_SCAN) && !r_off
                      && is_straight_slider(w_cell[PIECE_W-1:0])
                      && (w_cell[COLOR_BIT] != r_king_color);
    assign w_dir_end  = r_off || w_occupied || w_a_off;

    // NOTE: the latched board is pure datapath, only read while busy, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_board      <= bigBoard;
            r_king_pos   <= king_pos;
            r_king_color <= king_color;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_dir     <= DIR_UP;
            r_cursor  <= '0;
            r_off     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_check   <= 1'b0;
            r_att_pos <= '0;
            r_att_dir <= '0;
            r_att_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_SCAN;
                        r_busy    <= 1'b1;
                        r_check   <= 1'b0;
                        r_att_pos <= '0;
                        r_att_dir <= '0;
                        r_att_cnt <= '0;
                        r_dir     <= DIR_UP;
                        r_cursor  <= w_b_next;
                        r_off     <= w_b_off;
                    end
                end
                ST_SCAN: begin
                    if (w_attack) begin
                        r_att_cnt <= r_att_cnt + 3'd1;
                        if (!r_check) begin
                            r_check   <= 1'b1;
                            r_att_pos <= r_cursor;
                            r_att_dir <= r_dir;
                        end
                    end
                    if (!w_dir_end) begin
                        r_cursor <= w_a_next;
                    end else if (r_dir == DIR_DOWN) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_dir    <= r_dir + 2'd1;
                        r_cursor <= w_b_next;
                        r_off    <= w_b_off;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign check        = r_check;
    assign attacker_pos = r_att_pos;
    assign attacker_dir = r_att_dir;
    assign attack_count = r_att_cnt;

endmodule

// File: tb/tb_straight_check_ctrl.sv
// Directed bench for straight_check_ctrl: table of board scenarios plus
// hand-written sequences for ignored starts and mid-scan reset.
module tb_straight_check_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [255:0] bigBoard;
    logic [5:0]   king_pos;
    logic         king_color;
    logic         busy;
    logic         done;
    logic         check;
    logic [5:0]   attacker_pos;
    logic [1:0]   attacker_dir;
    logic [2:0]   attack_count;

    int checks   = 0;
    int failures = 0;

    straight_check_ctrl #(.CELL_W(4), .NSQ(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bigBoard     (bigBoard),
        .king_pos     (king_pos),
        .king_color   (king_color),
        .busy         (busy),
        .done         (done),
        .check        (check),
        .attacker_pos (attacker_pos),
        .attacker_dir (attacker_dir),
        .attack_count (attack_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] board;
        logic [5:0]   kpos;
        logic         kcol;
        logic         exp_check;
        logic [5:0]   exp_pos;
        logic [1:0]   exp_dir;
        logic [2:0]   exp_cnt;
        int           exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [255:0] put(input logic [255:0] b, input int sq, input logic [3:0] c);
        logic [255:0] r;
        r = b;
        r[sq*4 +: 4] = c;
        return r;
    endfunction

    // Start a scan at a negedge; lat = index of the done-high cycle (cycle 1 follows the start edge), -1 on timeout.
    task automatic do_scan(input logic [255:0] b, input logic [5:0] kp, input logic kc, output int lat);
        @(negedge clk);
        bigBoard   = b;
        king_pos   = kp;
        king_color = kc;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic check_results(input string tag, input vec_t v);
        chk({tag, " check"},        32'(check),        32'(v.exp_check));
        chk({tag, " attacker_pos"}, 32'(attacker_pos), 32'(v.exp_pos));
        chk({tag, " attacker_dir"}, 32'(attacker_dir), 32'(v.exp_dir));
        chk({tag, " attack_count"}, 32'(attack_count), 32'(v.exp_cnt));
    endtask

    initial begin
        logic [255:0] b;
        int lat;
        int done_seen;

        // 0: empty board, king in corner 0
        vecs[0] = '{'0, 6'd0, 1'b0, 1'b0, 6'd0, 2'd0, 3'd0, 17};
        // 1: white king 27, black rook 30 (DOWN)
        b = put('0, 30, 4'hC);
        vecs[1] = '{b, 6'd27, 1'b0, 1'b1, 6'd30, 2'd3, 3'd1, 14};
        // 2: as 1 plus white pawn 29 blocking
        vecs[2] = '{put(b, 29, 4'h1), 6'd27, 1'b0, 1'b0, 6'd0, 2'd0, 3'd0, 13};
        // 3: black queen 25 (UP) first, black rook 11 (LEFT) second
        vecs[3] = '{put(put('0, 25, 4'hD), 11, 4'hC), 6'd27, 1'b0, 1'b1, 6'd25, 2'd0, 3'd2, 13};
        // 4: own rook 30 and black bishop 24 only block
        vecs[4] = '{put(put('0, 30, 4'h4), 24, 4'hB), 6'd27, 1'b0, 1'b0, 6'd0, 2'd0, 3'd0, 14};
        // 5: all four directions attacked by adjacent black rooks
        b = put(put(put(put('0, 26, 4'hC), 19, 4'hC), 35, 4'hC), 28, 4'hC);
        vecs[5] = '{b, 6'd27, 1'b0, 1'b1, 6'd26, 2'd0, 3'd4, 5};

        rst_n      = 1'b0;
        start      = 1'b0;
        bigBoard   = '0;
        king_pos   = '0;
        king_color = 1'b0;
        #1;
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset attack_count", 32'(attack_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            do_scan(vecs[i].board, vecs[i].kpos, vecs[i].kcol, lat);
            chk({tag, " latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            chk({tag, " busy at done"}, 32'(busy), 0);
            check_results(tag, vecs[i]);
            @(negedge clk);
            chk({tag, " done single pulse"}, 32'(done), 0);
            check_results({tag, " held"}, vecs[i]);
        end

        // Black king in corner 63 attacked by white rooks on both open sides.
        begin
            vec_t v;
            v = '{put(put('0, 62, 4'h4), 55, 4'h5), 6'd63, 1'b1, 1'b1, 6'd62, 2'd0, 3'd2, 5};
            do_scan(v.board, v.kpos, v.kcol, lat);
            chk("corner63 latency", 32'(lat), 32'(v.exp_lat));
            check_results("corner63", v);
        end

        // Start and input changes mid-scan are ignored; start in the DONE cycle is ignored.
        @(negedge clk);
        bigBoard   = vecs[1].board;
        king_pos   = vecs[1].kpos;
        king_color = vecs[1].kcol;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("midscan busy cycle1", 32'(busy), 1);
        lat = 1;
        while (!done && lat < 100) begin
            if (lat == 3) begin
                start    = 1'b1;
                bigBoard = '0;
                king_pos = 6'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        chk("midscan latency", 32'(lat), 32'(vecs[1].exp_lat));
        check_results("midscan", vecs[1]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start in done busy", 32'(busy), 0);
        chk("start in done check held", 32'(check), 1);
        @(negedge clk);
        chk("start in done still idle", 32'(busy), 0);

        // Reset at cycle 5 of a scan aborts it with no done pulse.
        @(negedge clk);
        bigBoard   = vecs[3].board;
        king_pos   = vecs[3].kpos;
        king_color = vecs[3].kcol;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-reset check set", 32'(check), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset busy", 32'(busy), 0);
        chk("async reset check", 32'(check), 0);
        chk("async reset attacker_pos", 32'(attacker_pos), 0);
        chk("async reset attacker_dir", 32'(attacker_dir), 0);
        chk("async reset attack_count", 32'(attack_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        chk("no done after abort", 32'(done_seen), 0);
        do_scan(vecs[3].board, vecs[3].kpos, vecs[3].kcol, lat);
        chk("post-reset latency", 32'(lat), 32'(vecs[3].exp_lat));
        check_results("post-reset", vecs[3]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/straight_check_ctrl.md
STRAIGHT_CHECK_CTRL -- requirements
Module: straight_check_ctrl

Interface
REQ-001 SHALL have parameter CELL_W, default 4, meaning bits per board cell.
REQ-002 SHALL have parameter NSQ, default 64, meaning number of board squares.
REQ-003 SHALL have port clk, input, 1, meaning single rising-edge clock for all state.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, meaning one-cycle request to begin a check scan.
REQ-006 SHALL have port bigBoard, input, 256, meaning packed board: cell i = bigBoard[4i+3:4i], with [2:0] piece type and [3] colour (0 white, 1 black).
REQ-007 SHALL have port king_pos, input, 6, meaning king square: pos = col*8 + row.
REQ-008 SHALL have port king_color, input, 1, meaning colour of the defended king.
REQ-009 SHALL have port busy, output, 1, meaning a scan is in progress.
REQ-010 SHALL have port done, output, 1, meaning single-cycle pulse marking valid results.
REQ-011 SHALL have port check, output, 1, meaning king attacked along a rank or file.
REQ-012 SHALL have port attacker_pos, output, 6, meaning square of the first attacker found.
REQ-013 SHALL have port attacker_dir, output, 2, meaning direction of that attacker.
REQ-014 SHALL have port attack_count, output, 3, meaning number of attacked directions (0-4).

Function
REQ-015 SHALL use direction codes UP=0 (row-1), LEFT=1 (col-1), RIGHT=2 (col+1), DOWN=3 (row+1), scanned in that order.
REQ-016 SHALL use piece codes EMPTY=0, PAWN=1, KNIGHT=2, BISHOP=3, ROOK=4, QUEEN=5, KING=6.
REQ-017 SHALL, in IDLE with start=1, latch bigBoard, king_pos and king_color, clear all result outputs, raise busy, and enter SCAN at the same edge.
REQ-018 SHALL ignore start while busy=1; latched inputs SHALL NOT change during a scan.
REQ-019 SHALL examine exactly one square per SCAN cycle, beginning one step from king_pos in the current direction.
REQ-020 SHALL end a direction on the first non-empty square; an opponent ROOK or QUEEN counts as an attack, and any other piece blocks.
REQ-021 SHALL end a direction without examining any square when the next step would leave the board, i.e. row or col wraps past 0 or 7; this costs exactly one cycle.
REQ-022 SHALL give each direction a cost of max(1, squares examined) cycles.
REQ-023 SHALL, on each attack, increment attack_count; on the first attack only, it SHALL set check=1, attacker_pos and attacker_dir.
REQ-024 SHALL, after DOWN completes, enter DONE: done=1 for one cycle, busy=0, then return to IDLE.
REQ-025 SHALL hold all result outputs after DONE until the next accepted start.
REQ-026 SHALL give a total latency, from the start edge to the done-high cycle, of (sum of direction costs)+1 cycles.
REQ-027 SHALL, when a start arrives in the DONE cycle, ignore it.

Reset
REQ-028 SHALL, on rst_n=0 and regardless of clk, go to IDLE and drive busy, done, check, attacker_pos, attacker_dir and attack_count to 0.
REQ-029 SHALL abort an in-progress scan on reset with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Structure
REQ-030 SHALL take piece codes, direction codes, CELL_W and the colour-bit index from the shared package chess_pkg, used by the board scanners too.
REQ-031 SHALL contain one sub-module square_stepper: combinational, (pos, dir) -> (next_pos, off_board).
REQ-032 SHALL implement the FSM as a registered state IDLE/SCAN/DONE, a 2-bit direction register and a 6-bit cursor.

Verification
REQ-033 SHALL cover: empty board, king_pos=0, start -> done 17 cycles after start, check=0, attack_count=0.
REQ-034 SHALL cover: white king at 27, black rook at 30 -> check=1, attacker_pos=30, attacker_dir=3, attack_count=1, done at cycle 14.
REQ-035 SHALL cover: as REQ-034 plus white pawn at 29 -> check=0, attack_count=0.
REQ-036 SHALL cover: white king at 27, black queen at 25, black rook at 11 -> attacker_pos=25, attacker_dir=0, attack_count=2.
REQ-037 SHALL cover: white king at 27, white rook at 30, black bishop at 24 -> check=0 (own piece and non-slider block).
REQ-038 SHALL cover: start mid-scan ignored; rst_n pulsed low at cycle 5 -> all outputs 0 immediately, no done; a new start then gives the correct result.
